// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, drives the instruction
// memory read port, resolves jumps (opcode F) with a single bubble, absorbs
// a decode stall through a one-entry skid register and halts on jump-to-self.
//
// state | meaning
// IDLE  | out of reset, no fetching, waiting for start
// RUN   | issuing one read per unstalled cycle, presenting returned words
// HALT  | jump-to-self seen; no reads, output drains to NOP, waits for start
module instr_fetch #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stall,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [15:0]       imem_data,
  output logic [15:0]       instr,
  output logic [3:0]        opcode,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [3:0]        OP_JUMP = 4'hF;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // one read can be outstanding at a time (memory latency is one cycle)
  logic              fl_valid_q, fl_valid_d;
  logic              fl_squash_q, fl_squash_d;
  logic [ADDR_W-1:0] fl_addr_q, fl_addr_d;

  logic              skid_full_q, skid_full_d;
  logic [15:0]       skid_data_q, skid_data_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;

  logic [15:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;

  logic              start_ok;
  logic              issue;
  logic              ret_ok;
  logic              out_load;
  logic              src_valid;
  logic [15:0]       src_data;
  logic [ADDR_W-1:0] src_addr;
  logic              load_word;
  logic              is_jump;
  logic              jump_self;
  logic [ADDR_W-1:0] jump_tgt;
  logic              ret_to_skid;

  // Read issue, returning-word qualification and output source selection
  always_comb begin
    start_ok  = start && (state_q != RUN);
    issue     = (state_q == RUN) && !stall;
    ret_ok    = (state_q == RUN) && fl_valid_q && !fl_squash_q;
    out_load  = !valid_q || !stall;
    src_valid = 1'b0;
    src_data  = 16'h0000;
    src_addr  = '0;
    if (state_q == RUN) begin
      if (skid_full_q) begin
        src_valid = 1'b1;
        src_data  = skid_data_q;
        src_addr  = skid_addr_q;
      end else if (ret_ok) begin
        src_valid = 1'b1;
        src_data  = imem_data;
        src_addr  = fl_addr_q;
      end
    end
    load_word = out_load && src_valid;
    is_jump   = load_word && (src_data[15:12] == OP_JUMP);
    jump_tgt  = src_data[ADDR_W-1:0];
    jump_self = is_jump && (jump_tgt == src_addr);
    // a returning word the output register does not take this cycle
    ret_to_skid = ret_ok && !(out_load && !skid_full_q);
  end

  // Next-state, program counter, in-flight tag, skid and output register
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fl_valid_d  = issue;
    fl_addr_d   = pc_q;
    fl_squash_d = is_jump;
    skid_full_d = skid_full_q;
    skid_data_d = skid_data_q;
    skid_addr_d = skid_addr_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    pc_out_d    = pc_out_q;

    if (issue) begin
      pc_d = pc_q + PC_ONE;
    end
    // a jump redirects the pc and kills the read issued alongside it
    if (is_jump) begin
      pc_d = jump_tgt;
    end

    if (out_load) begin
      instr_d = src_valid ? src_data : 16'h0000;
      valid_d = src_valid;
      if (src_valid) begin
        pc_out_d = src_addr;
      end
    end

    if (out_load && skid_full_q) begin
      skid_full_d = 1'b0;
    end
    // skid only accepts when empty or draining; nothing after a jump is kept
    if (ret_to_skid && (!skid_full_q || out_load) && !is_jump) begin
      skid_full_d = 1'b1;
      skid_data_d = imem_data;
      skid_addr_d = fl_addr_q;
    end

    if (jump_self) begin
      state_d     = HALT;
      skid_full_d = 1'b0;
    end

    if (start_ok) begin
      state_d     = RUN;
      pc_d        = start_addr;
      fl_valid_d  = 1'b0;
      fl_squash_d = 1'b0;
      skid_full_d = 1'b0;
      instr_d     = 16'h0000;
      valid_d     = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      fl_valid_q  <= 1'b0;
      fl_squash_q <= 1'b0;
      fl_addr_q   <= '0;
      skid_full_q <= 1'b0;
      skid_data_q <= 16'h0000;
      skid_addr_q <= '0;
      instr_q     <= 16'h0000;
      valid_q     <= 1'b0;
      pc_out_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      fl_valid_q  <= fl_valid_d;
      fl_squash_q <= fl_squash_d;
      fl_addr_q   <= fl_addr_d;
      skid_full_q <= skid_full_d;
      skid_data_q <= skid_data_d;
      skid_addr_q <= skid_addr_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      pc_out_q    <= pc_out_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_rd     = issue;
  assign instr       = instr_q;
  assign opcode      = instr_q[15:12];
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with fixed expectations plus a
// randomized run checked against a program-walk model of the fetch stream.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_addr = 8'h00;
  logic        stall = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        instr_valid;
  logic [7:0]  pc_out;
  logic        halted;

  logic [15:0] mem [0:255];
  int checks = 0;
  int failures = 0;

  instr_fetch #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .stall(stall), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory, one-cycle read latency
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  task automatic fill_default();
    for (int a = 0; a < 256; a++) mem[a] = 16'h1000 | 16'(a);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; start_addr = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // cycle 0 of a run: start high during this cycle
  task automatic start_at(input logic [7:0] a, input logic s);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; stall = s;
    @(negedge clk);
  endtask

  task automatic cyc(input logic s);
    @(posedge clk); #1;
    start = 1'b0; stall = s;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({imem_addr, imem_rd, instr, opcode, instr_valid, pc_out, halted} !== 39'h0) begin
      failures++;
      $display("FAIL reset_values: got addr=%h rd=%b instr=%h op=%h v=%b pc=%h h=%b required all zero",
               imem_addr, imem_rd, instr, opcode, instr_valid, pc_out, halted);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_linear();
    logic [15:0] w [4];
    logic [3:0]  op [4];
    w  = '{16'h2001, 16'hC123, 16'h5045, 16'h4012};
    op = '{4'h2, 4'hC, 4'h5, 4'h4};
    fill_default();
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = w[i];
    do_reset();
    start_at(8'h10, 1'b0);
    checks++;
    if (imem_rd !== 1'b0) begin failures++; $display("FAIL lin_c0_rd: got %b required 0", imem_rd); end
    cyc(1'b0);
    checks++;
    if ({imem_rd, imem_addr} !== {1'b1, 8'h10}) begin
      failures++; $display("FAIL lin_c1_issue: got rd=%b addr=%h required rd=1 addr=10", imem_rd, imem_addr);
    end
    cyc(1'b0);
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL lin_c2_valid: got %b required 0", instr_valid); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0);
      checks++;
      if ({instr_valid, pc_out, instr, opcode} !== {1'b1, 8'(8'h10 + i), w[i], op[i]}) begin
        failures++;
        $display("FAIL lin_word%0d: got v=%b pc=%h instr=%h op=%h required v=1 pc=%h instr=%h op=%h",
                 i, instr_valid, pc_out, instr, opcode, 8'(8'h10 + i), w[i], op[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic [7:0]  ep [6];
    logic [15:0] ew [6];
    logic        ev [6];
    fill_default();
    mem[8'h10] = 16'h2001; mem[8'h11] = 16'hC123; mem[8'h12] = 16'hF020; mem[8'h13] = 16'h4012;
    ev = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ep = '{8'h10, 8'h11, 8'h12, 8'h00, 8'h20, 8'h21};
    ew = '{16'h2001, 16'hC123, 16'hF020, 16'h0000, 16'h1020, 16'h1021};
    do_reset();
    start_at(8'h10, 1'b0);
    cyc(1'b0); cyc(1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0);
      checks++;
      if (ev[i] ? ({instr_valid, pc_out, instr, opcode} !== {1'b1, ep[i], ew[i], ew[i][15:12]})
                : ({instr_valid, instr, opcode} !== 21'h0)) begin
        failures++;
        $display("FAIL jump_seq%0d: got v=%b pc=%h instr=%h op=%h required v=%b pc=%h instr=%h",
                 i, instr_valid, pc_out, instr, opcode, ev[i], ep[i], ew[i]);
      end
    end
  endtask

  task automatic test_stall();
    fill_default();
    mem[8'h10] = 16'h2001; mem[8'h11] = 16'hC123; mem[8'h12] = 16'h5045; mem[8'h13] = 16'h4012;
    do_reset();
    start_at(8'h10, 1'b0);
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      checks++;
      if ({imem_rd, instr_valid, pc_out, instr} !== {1'b0, 1'b1, 8'h11, 16'hC123}) begin
        failures++;
        $display("FAIL stall_hold%0d: got rd=%b v=%b pc=%h instr=%h required rd=0 v=1 pc=11 instr=c123",
                 i, imem_rd, instr_valid, pc_out, instr);
      end
    end
    cyc(1'b0);
    checks++;
    if ({imem_rd, imem_addr, pc_out, instr} !== {1'b1, 8'h13, 8'h11, 16'hC123}) begin
      failures++;
      $display("FAIL stall_release: got rd=%b addr=%h pc=%h instr=%h required rd=1 addr=13 pc=11 instr=c123",
               imem_rd, imem_addr, pc_out, instr);
    end
    cyc(1'b0);
    checks++;
    if ({instr_valid, pc_out, instr} !== {1'b1, 8'h12, 16'h5045}) begin
      failures++; $display("FAIL stall_skid: got v=%b pc=%h instr=%h required v=1 pc=12 instr=5045", instr_valid, pc_out, instr);
    end
    cyc(1'b0);
    checks++;
    if ({instr_valid, pc_out, instr} !== {1'b1, 8'h13, 16'h4012}) begin
      failures++; $display("FAIL stall_after: got v=%b pc=%h instr=%h required v=1 pc=13 instr=4012", instr_valid, pc_out, instr);
    end
    cyc(1'b0);
    checks++;
    if ({instr_valid, pc_out, instr} !== {1'b1, 8'h14, 16'h1014}) begin
      failures++; $display("FAIL stall_next: got v=%b pc=%h instr=%h required v=1 pc=14 instr=1014", instr_valid, pc_out, instr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ep [4];
    ep = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    fill_default();
    do_reset();
    start_at(8'hFE, 1'b0);
    cyc(1'b0); cyc(1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0);
      checks++;
      if ({instr_valid, pc_out, instr} !== {1'b1, ep[i], 16'h1000 | 16'(ep[i])}) begin
        failures++;
        $display("FAIL wrap%0d: got v=%b pc=%h instr=%h required v=1 pc=%h", i, instr_valid, pc_out, instr, ep[i]);
      end
    end
  endtask

  task automatic test_halt();
    fill_default();
    mem[8'h30] = 16'hF030;
    do_reset();
    start_at(8'h30, 1'b0);
    cyc(1'b0); cyc(1'b0);
    cyc(1'b0);
    checks++;
    if ({instr_valid, instr, opcode, halted, imem_rd} !== {1'b1, 16'hF030, 4'hF, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL halt_present: got v=%b instr=%h op=%h h=%b rd=%b required v=1 instr=f030 op=f h=1 rd=0",
               instr_valid, instr, opcode, halted, imem_rd);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0);
      checks++;
      if ({instr_valid, halted, imem_rd} !== 3'b010) begin
        failures++; $display("FAIL halt_idle%0d: got v=%b h=%b rd=%b required v=0 h=1 rd=0", i, instr_valid, halted, imem_rd);
      end
    end
    start_at(8'h00, 1'b0);
    cyc(1'b0);
    checks++;
    if ({halted, imem_rd, imem_addr} !== {1'b0, 1'b1, 8'h00}) begin
      failures++; $display("FAIL halt_restart: got h=%b rd=%b addr=%h required h=0 rd=1 addr=00", halted, imem_rd, imem_addr);
    end
    cyc(1'b0); cyc(1'b0);
    checks++;
    if ({instr_valid, pc_out, instr} !== {1'b1, 8'h00, 16'h1000}) begin
      failures++; $display("FAIL halt_resume: got v=%b pc=%h instr=%h required v=1 pc=00 instr=1000", instr_valid, pc_out, instr);
    end
    // start while the halting jump is held by a stall
    do_reset();
    start_at(8'h30, 1'b0);
    cyc(1'b0); cyc(1'b0);
    cyc(1'b1); cyc(1'b1);
    start_at(8'h50, 1'b1);
    checks++;
    if ({instr_valid, instr, halted} !== {1'b1, 16'hF030, 1'b1}) begin
      failures++; $display("FAIL halt_held: got v=%b instr=%h h=%b required v=1 instr=f030 h=1", instr_valid, instr, halted);
    end
    cyc(1'b1);
    checks++;
    if ({instr_valid, instr, halted, imem_rd} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL halt_start_clear: got v=%b instr=%h h=%b rd=%b required v=0 instr=0000 h=0 rd=0",
               instr_valid, instr, halted, imem_rd);
    end
    cyc(1'b0);
    checks++;
    if ({imem_rd, imem_addr} !== {1'b1, 8'h50}) begin
      failures++; $display("FAIL halt_start_issue: got rd=%b addr=%h required rd=1 addr=50", imem_rd, imem_addr);
    end
    cyc(1'b0); cyc(1'b0);
    checks++;
    if ({instr_valid, pc_out, instr} !== {1'b1, 8'h50, 16'h1050}) begin
      failures++; $display("FAIL halt_start_word: got v=%b pc=%h instr=%h required v=1 pc=50 instr=1050", instr_valid, pc_out, instr);
    end
  endtask

  task automatic test_reset_mid();
    fill_default();
    do_reset();
    start_at(8'h10, 1'b0);
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    cyc(1'b1); cyc(1'b1);
    @(posedge clk); #1;
    stall = 1'b1; rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_addr, imem_rd, instr, opcode, instr_valid, pc_out, halted} !== 39'h0) begin
      failures++;
      $display("FAIL reset_mid: got addr=%h rd=%b instr=%h op=%h v=%b pc=%h h=%b required all zero",
               imem_addr, imem_rd, instr, opcode, instr_valid, pc_out, halted);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0);
      checks++;
      if ({imem_rd, instr_valid} !== 2'b00) begin
        failures++; $display("FAIL reset_mid_quiet%0d: got rd=%b v=%b required rd=0 v=0", i, imem_rd, instr_valid);
      end
    end
    start_at(8'h20, 1'b0);
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    checks++;
    if ({instr_valid, pc_out, instr} !== {1'b1, 8'h20, 16'h1020}) begin
      failures++; $display("FAIL reset_mid_restart: got v=%b pc=%h instr=%h required v=1 pc=20 instr=1020", instr_valid, pc_out, instr);
    end
  endtask

  // random programs and stalls; model walks the program in architectural order
  task automatic test_random();
    logic [15:0] w;
    logic [7:0]  sa, ea;
    logic        s, halt_seen, done, self_at;
    int          idle;
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 256; a++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 7) == 0) w[15:12] = 4'hF;
        else if (w[15:12] == 4'hF) w[15:12] = 4'h3;
        if (w[15:12] == 4'hF && $urandom_range(0, 11) == 0) w[7:0] = 8'(a);
        mem[a] = w;
      end
      do_reset();
      sa = 8'($urandom_range(0, 255));
      start_at(sa, 1'b0);
      ea = sa; halt_seen = 1'b0; done = 1'b0; idle = 0;
      for (int c = 1; c < 250; c++) begin
        s = ($urandom_range(0, 3) == 0);
        cyc(s);
        self_at = (mem[ea][15:12] == 4'hF) && (mem[ea][7:0] == ea);
        if (instr_valid === 1'b1 && !done && self_at) halt_seen = 1'b1;
        checks++;
        if (imem_rd !== (!s && !halt_seen)) begin
          failures++; $display("FAIL rnd_rd t%0d c%0d: got %b required %b", t, c, imem_rd, (!s && !halt_seen));
        end
        checks++;
        if (halted !== halt_seen) begin
          failures++; $display("FAIL rnd_halted t%0d c%0d: got %b required %b", t, c, halted, halt_seen);
        end
        if (instr_valid === 1'b1) begin
          idle = 0;
          checks++;
          if (done || ({pc_out, instr, opcode} !== {ea, mem[ea], mem[ea][15:12]})) begin
            failures++;
            $display("FAIL rnd_word t%0d c%0d: got pc=%h instr=%h op=%h required pc=%h instr=%h (after_halt=%b)",
                     t, c, pc_out, instr, opcode, ea, mem[ea], done);
          end
          if (!s && !done) begin
            if (mem[ea][15:12] == 4'hF) begin
              if (self_at) done = 1'b1;
              else ea = mem[ea][7:0];
            end else begin
              ea = ea + 8'd1;
            end
          end
        end else begin
          checks++;
          if ({instr, opcode} !== 20'h0) begin
            failures++; $display("FAIL rnd_nop t%0d c%0d: got instr=%h op=%h required 0", t, c, instr, opcode);
          end
          if (!s && !halt_seen) idle++;
          checks++;
          if (idle > 6) begin
            failures++; $display("FAIL rnd_progress t%0d c%0d: got %0d idle cycles required <= 6", t, c, idle);
          end
        end
      end
    end
  endtask

  initial begin
    fill_default();
    test_reset();
    test_linear();
    test_jump();
    test_stall();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the 16-bit pipelined CPU, sitting upstream of the control decoder: it drives the instruction-memory read port and presents one 16-bit instruction per cycle whose opcode field feeds the decoder. It owns the program counter, resolves jumps (opcode 4'hF) locally with a one-cycle bubble, honours a decode-stage stall through a one-entry skid register, and halts on a jump-to-self.

## Interface
- ADDR_W, 8, instruction-memory address width; PC and jump target width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin fetching at start_addr (accepted in IDLE or HALT only)
- start_addr  in  ADDR_W  first fetch address, sampled with start
- stall  in  1  decode stage cannot accept; hold instr/instr_valid/pc_out
- imem_addr  out  ADDR_W  read address
- imem_rd  out  1  read strobe; memory returns data on imem_data the following cycle
- imem_data  in  16  read data, valid the cycle after imem_rd
- instr  out  16  instruction to decode; 16'h0000 (NOP) whenever instr_valid=0
- opcode  out  4  instr[15:12], combinational, to the control decoder
- instr_valid  out  1  instr holds a real instruction
- pc_out  out  ADDR_W  address instr was fetched from
- halted  out  1  high in HALT state

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE. IDLE/HALT + start -> RUN, pc <= start_addr, skid and in-flight marks cleared, halted <= 0. RUN + jump-to-self loaded -> HALT. start in RUN ignored.
- Issue: imem_rd = (state==RUN) && !stall, combinational; imem_addr = pc. Each issued read increments pc mod 2^ADDR_W (wrap 0xFF -> 0x00 at default width). An in-flight tag register records address and a squash bit per issued read.
- Return: a non-squashed word returning on imem_data goes to the output register if it may load, else to the skid register. Squashed words are dropped.
- Output register loads when !instr_valid || !stall. Source priority: skid (if full), then returning word, else load NOP with instr_valid=0.
- Skid holds at most one word: reads stop the same cycle stall is seen, so only the read issued the cycle before can land. Skid is never written while full.
- Jump: when a word with opcode 4'hF loads into the output register (from either source), pc <= {instr[ADDR_W-1:0]} target; any read issued in that same cycle is tagged squashed. The jump word itself is presented with instr_valid=1 so the decoder asserts j.
- Jump-to-self (target == its own address): word presented, then state -> HALT; imem_rd=0, pending/in-flight data dropped, instr_valid falls to 0 once the jump word is consumed (stall low).
- start in HALT during a held jump word: output cleared to NOP the next cycle.

## Timing
- Reset values: imem_addr=0, imem_rd=0, instr=16'h0000, opcode=0, instr_valid=0, pc_out=0, halted=0; state IDLE, skid empty, in-flight tags cleared. Reset mid-operation discards all in-flight data.
- Latency: start at cycle 0 -> first imem_rd in cycle 1 -> instr_valid in cycle 3. Steady-state throughput one instruction/cycle.
- Jump at address A presented valid in cycle n: cycle n+1 instr_valid=0 (one bubble, opcode 0); target instruction valid in cycle n+2.
- Stall high in cycle s: instr/pc_out held from s until release; imem_rd=0 from s. Release in cycle r: skid word presented in r+1, read reissued in r, its data presented in r+2 with no gap.
- Stall while instr_valid=0: no reads issued; output stays NOP.
- Simultaneous stall release and skid word being a jump: jump taken from skid, read issued in r is squashed.

## Test plan
- Reset then start with start_addr=0x10, memory 0x10..0x13 = 16'h2001,16'hC123,16'h5045,16'h4012 -> instr_valid from cycle 3, pc_out 0x10,0x11,0x12,0x13 on consecutive cycles, opcode 2,C,5,4.
- Word at 0x12 = 16'hF020 -> 16'hF020 valid with opcode F, next cycle instr_valid=0/instr=0, then pc_out=0x20; word at 0x13 never presented.
- Stall for 3 cycles while 0x11 is valid -> instr held at 0x11 word, imem_rd=0 for those cycles, 0x12 (from skid) presented the cycle after release, 0x13 the next, no duplicates or losses.
- Start at 0xFE with linear code -> pc_out sequence 0xFE, 0xFF, 0x00, 0x01.
- Word at 0x30 = 16'hF030 -> presented once, halted=1, imem_rd stays 0; start with start_addr=0x00 -> halted=0, fetch resumes at 0x00.
- Assert rst_n low during a stall with skid full -> all outputs at reset values immediately; after release, no reads until start.
